// File: rtl/apb_master.sv
// APB requester: turns cmd_* requests into IDLE/SETUP/ACCESS transfers.
// Optional ACCESS timeout abort enabled by defining APB_MASTER_TIMEOUT_EN.
`timescale 1ns/1ps
module apb_master #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8,
    parameter int TIMEOUT    = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic [ADDR_WIDTH-1:0] paddr,
    output logic                  pwrite,
    output logic                  psel,
    output logic                  penable,
    output logic [DATA_WIDTH-1:0] pwdata,
    output logic                  pstrb,
    input  logic [DATA_WIDTH-1:0] prdata,
    input  logic                  pready,
    input  logic                  pslverr
);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS
    } state_t;

    state_t                state, state_d;
    logic                  cmd_ready_d;
    logic                  psel_d;
    logic                  penable_d;
    logic                  pwrite_d;
    logic                  pstrb_d;
    logic [ADDR_WIDTH-1:0] paddr_d;
    logic [DATA_WIDTH-1:0] pwdata_d;
    logic                  rsp_valid_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_d;
    logic                  rsp_err_d;

    if (TIMEOUT < 1) begin : g_tmo_range
        $error("apb_master: TIMEOUT must be at least 1");
    end

`ifdef APB_MASTER_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] tmo_cnt, tmo_cnt_d;
    logic             tmo_hit;

    // this low-pready cycle is the one that brings the count to TIMEOUT
    assign tmo_hit = (tmo_cnt == CNT_W'(TIMEOUT - 1));
`endif

    // next state and next register values for every output
    always_comb begin
        state_d     = state;
        cmd_ready_d = cmd_ready;
        psel_d      = psel;
        penable_d   = penable;
        pwrite_d    = pwrite;
        pstrb_d     = pstrb;
        paddr_d     = paddr;
        pwdata_d    = pwdata;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata;
        rsp_err_d   = rsp_err;
`ifdef APB_MASTER_TIMEOUT_EN
        tmo_cnt_d   = tmo_cnt;
`endif
        unique case (state)
            IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    state_d     = SETUP;
                    cmd_ready_d = 1'b0;
                    psel_d      = 1'b1;
                    penable_d   = 1'b0;
                    pwrite_d    = cmd_write;
                    pstrb_d     = cmd_write;
                    paddr_d     = cmd_addr;
                    pwdata_d    = cmd_wdata;
                end
            end
            SETUP: begin
                state_d   = ACCESS;
                penable_d = 1'b1;
`ifdef APB_MASTER_TIMEOUT_EN
                tmo_cnt_d = '0;
`endif
            end
            ACCESS: begin
                // pready is checked first so it wins over a same-edge timeout
                if (pready) begin
                    state_d     = IDLE;
                    cmd_ready_d = 1'b1;
                    psel_d      = 1'b0;
                    penable_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = pwrite ? '0 : prdata;
                    rsp_err_d   = pslverr;
                end
`ifdef APB_MASTER_TIMEOUT_EN
                else if (tmo_hit) begin
                    state_d     = IDLE;
                    cmd_ready_d = 1'b1;
                    psel_d      = 1'b0;
                    penable_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = '0;
                    rsp_err_d   = 1'b1;
                end else begin
                    tmo_cnt_d = tmo_cnt + 1'b1;
                end
`endif
            end
            default: begin
                state_d     = IDLE;
                cmd_ready_d = 1'b1;
                psel_d      = 1'b0;
                penable_d   = 1'b0;
            end
        endcase
    end

    // state and all outputs are registered; reset forces IDLE at once
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cmd_ready <= 1'b1;
            psel      <= 1'b0;
            penable   <= 1'b0;
            pwrite    <= 1'b0;
            pstrb     <= 1'b0;
            paddr     <= '0;
            pwdata    <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            state     <= state_d;
            cmd_ready <= cmd_ready_d;
            psel      <= psel_d;
            penable   <= penable_d;
            pwrite    <= pwrite_d;
            pstrb     <= pstrb_d;
            paddr     <= paddr_d;
            pwdata    <= pwdata_d;
            rsp_valid <= rsp_valid_d;
            rsp_rdata <= rsp_rdata_d;
            rsp_err   <= rsp_err_d;
        end
    end

`ifdef APB_MASTER_TIMEOUT_EN
    // count of ACCESS cycles spent waiting on pready
    always_ff @(posedge clk or posedge rst) begin
        if (rst) tmo_cnt <= '0;
        else     tmo_cnt <= tmo_cnt_d;
    end
`endif

endmodule

// File: tb/tb_apb_master.sv
// Directed bench for apb_master with a small APB completer model.
// Define APB_MASTER_TIMEOUT_EN to also exercise the timeout abort.
`timescale 1ns/1ps
module tb_apb_master;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_write;
    logic [7:0] cmd_addr;
    logic [7:0] cmd_wdata;
    logic       rsp_valid;
    logic [7:0] rsp_rdata;
    logic       rsp_err;
    logic [7:0] paddr;
    logic       pwrite;
    logic       psel;
    logic       penable;
    logic [7:0] pwdata;
    logic       pstrb;
    logic [7:0] prdata;
    logic       pready;
    logic       pslverr;

    int n_chk  = 0;
    int n_fail = 0;

    apb_master #(
        .ADDR_WIDTH(8),
        .DATA_WIDTH(8),
        .TIMEOUT   (16)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_write(cmd_write),
        .cmd_addr (cmd_addr),
        .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid),
        .rsp_rdata(rsp_rdata),
        .rsp_err  (rsp_err),
        .paddr    (paddr),
        .pwrite   (pwrite),
        .psel     (psel),
        .penable  (penable),
        .pwdata   (pwdata),
        .pstrb    (pstrb),
        .prdata   (prdata),
        .pready   (pready),
        .pslverr  (pslverr)
    );

    always #5 clk = ~clk;

    // completer model: fixed wait count per transfer, optional error
    logic [7:0] mem [256];
    int         cfg_waits;
    logic       cfg_err;
    int         wcnt;

    assign pready  = penable && (wcnt >= cfg_waits);
    assign pslverr = pready && cfg_err;
    assign prdata  = mem[paddr];

    always @(posedge clk) begin
        if (penable && !pready) wcnt <= wcnt + 1;
        else                    wcnt <= 0;
        if (psel && penable && pready && pwrite && !cfg_err)
            mem[paddr] <= pwdata;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // one transfer; lat counts cycles inclusively from the accept
    // cycle to the rsp_valid cycle (minimum 4)
    task automatic xfer(input string tag, input logic w,
                        input logic [7:0] a, input logic [7:0] d,
                        input int waits, input logic err,
                        input int exp_lat, input logic [7:0] exp_rd,
                        input logic exp_err);
        int lat;
        bit seen;
        bit seq_ok;
        int unstable;
        cfg_waits = waits;
        cfg_err   = err;
        @(negedge clk);
        chk({tag, ".ready_before"}, cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_addr  = a;
        cmd_wdata = d;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = 8'h00;
        cmd_wdata = 8'h00;
        lat      = 1;
        seen     = 1'b0;
        seq_ok   = 1'b1;
        unstable = 0;
        while (!seen && lat < 60) begin
            @(negedge clk);
            lat++;
            if (rsp_valid) begin
                seen = 1'b1;
            end else begin
                if (lat == 2 && !(psel && !penable)) seq_ok = 1'b0;
                if (lat >= 3 && !(psel && penable)) seq_ok = 1'b0;
                if (cmd_ready) seq_ok = 1'b0;
                if (paddr !== a || pwrite !== w || pstrb !== w ||
                    pwdata !== d)
                    unstable++;
            end
        end
        chk({tag, ".rsp_seen"}, seen, 1);
        chk({tag, ".latency"}, lat, exp_lat);
        chk({tag, ".setup_access"}, seq_ok, 1);
        chk({tag, ".bus_stable"}, unstable, 0);
        chk({tag, ".rdata"}, rsp_rdata, exp_rd);
        chk({tag, ".err"}, rsp_err, exp_err);
        chk({tag, ".ready_rsp"}, cmd_ready, 1);
        chk({tag, ".psel_rsp"}, {psel, penable}, 0);
        @(negedge clk);
        chk({tag, ".pulse_end"}, rsp_valid, 0);
        chk({tag, ".rdata_hold"}, rsp_rdata, exp_rd);
        chk({tag, ".err_hold"}, rsp_err, exp_err);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed=running expected=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int extra;
        for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'h3C;
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = 8'h00;
        cmd_wdata = 8'h00;
        cfg_waits = 0;
        cfg_err   = 1'b0;
        #12;
        chk("rst.cmd_ready", cmd_ready, 1);
        chk("rst.psel_penable", {psel, penable}, 0);
        chk("rst.pwrite_pstrb", {pwrite, pstrb}, 0);
        chk("rst.paddr", paddr, 0);
        chk("rst.pwdata", pwdata, 0);
        chk("rst.rsp", {rsp_valid, rsp_err, rsp_rdata}, 0);
        @(negedge clk);
        rst = 1'b0;

        xfer("wr", 1'b1, 8'h05, 8'hA5, 0, 1'b0, 4, 8'h00, 1'b0);
        xfer("rd", 1'b0, 8'h05, 8'h00, 0, 1'b0, 4, 8'hA5, 1'b0);
        xfer("wr_wait", 1'b1, 8'h07, 8'h5A, 3, 1'b0, 7, 8'h00, 1'b0);
        xfer("rd_wait", 1'b0, 8'h07, 8'h00, 3, 1'b0, 7, 8'h5A, 1'b0);
        xfer("wr_err", 1'b1, 8'h10, 8'h99, 0, 1'b1, 4, 8'h00, 1'b1);
        xfer("rd_after_err", 1'b0, 8'h10, 8'h00, 0, 1'b0, 4, 8'h2C, 1'b0);

        // reset in the middle of a stalled ACCESS
        cfg_waits = 5;
        cfg_err   = 1'b0;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_addr  = 8'h20;
        cmd_wdata = 8'h77;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("mid.in_access", {psel, penable}, 2'b11);
        #2;
        rst = 1'b1;
        #1;
        chk("mid.bus_drop", {psel, penable}, 0);
        chk("mid.ready", cmd_ready, 1);
        chk("mid.paddr", paddr, 0);
        @(negedge clk);
        rst   = 1'b0;
        extra = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (rsp_valid || psel) extra++;
        end
        chk("mid.no_rsp", extra, 0);
        chk("mid.ready_after", cmd_ready, 1);
        xfer("rd_post_rst", 1'b0, 8'h20, 8'h00, 0, 1'b0, 4, 8'h1C, 1'b0);

`ifdef APB_MASTER_TIMEOUT_EN
        xfer("tmo", 1'b0, 8'h05, 8'h00, 1000, 1'b0, 19, 8'h00, 1'b1);
        xfer("tmo_race", 1'b0, 8'h05, 8'h00, 15, 1'b0, 19, 8'hA5, 1'b0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/apb_master.md
APB_MASTER -- requirements
Module: apb_master

Interface
REQ-001 Parameter ADDR_WIDTH, default 8, width of cmd_addr and paddr.
REQ-002 Parameter DATA_WIDTH, default 8, width of all data buses.
REQ-003 Parameter TIMEOUT, default 16, number of ACCESS cycles with pready low before abort; used only when the timeout feature is compiled in.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 cmd_valid  in  1  command request.
REQ-007 cmd_ready  out  1  command accepted when cmd_valid and cmd_ready are both high at a rising edge.
REQ-008 cmd_write  in  1  1 = write, 0 = read.
REQ-009 cmd_addr  in  ADDR_WIDTH  transfer address.
REQ-010 cmd_wdata  in  DATA_WIDTH  write data.
REQ-011 rsp_valid  out  1  one-cycle completion pulse.
REQ-012 rsp_rdata  out  DATA_WIDTH  read data; valid with rsp_valid.
REQ-013 rsp_err  out  1  error status; valid with rsp_valid.
REQ-014 paddr, pwrite, psel, penable, pwdata, pstrb  out  ADDR_WIDTH/1/1/1/DATA_WIDTH/1  APB requester outputs to the apb_slave.
REQ-015 prdata, pready, pslverr  in  DATA_WIDTH/1/1  APB completer responses.

Function
REQ-016 The block SHALL implement the states IDLE, SETUP and ACCESS, with every output driven from a register.
REQ-017 IDLE: cmd_ready=1, psel=0, penable=0; on command acceptance, latch addr/write/wdata into paddr/pwrite/pwdata and go to SETUP.
REQ-018 SETUP: psel=1, penable=0, cmd_ready=0; SETUP SHALL last exactly one cycle and then go to ACCESS.
REQ-019 ACCESS: psel=1, penable=1; SHALL hold until pready is sampled high.
REQ-020 paddr, pwrite, pwdata and pstrb SHALL remain stable from SETUP through the final ACCESS cycle.
REQ-021 pstrb SHALL equal pwrite: 1 for writes and 0 for reads.
REQ-022 On the edge where pready=1 in ACCESS, the block SHALL register the response: rsp_rdata=prdata for reads (0 for writes) and rsp_err=pslverr.
REQ-023 At that same edge the block SHALL assert rsp_valid for exactly the next cycle and return to IDLE with psel=0 and penable=0.
REQ-024 Latency: accept at edge N gives SETUP in cycle N+1, ACCESS from N+2, and rsp_valid one cycle after the pready edge; minimum 4 cycles from acceptance to rsp_valid.
REQ-025 cmd_ready SHALL be 0 in SETUP and ACCESS, and SHALL be 1 again in the cycle that rsp_valid is high.
REQ-026 Back-to-back commands SHALL therefore insert one IDLE cycle between transfers.
REQ-027 rsp_rdata and rsp_err SHALL hold their last values when rsp_valid=0.
REQ-028 cmd_valid while cmd_ready=0 SHALL be ignored; no command is queued.

Reset
REQ-029 While rst is high, the block SHALL be in IDLE with cmd_ready=1, psel=0, penable=0, pwrite=0, pstrb=0, paddr=0, pwdata=0, rsp_valid=0, rsp_rdata=0 and rsp_err=0, taking effect immediately without a clock edge.
REQ-030 Reset asserted mid-transfer SHALL abort the transfer with no rsp_valid pulse for it.

Configuration
REQ-031 With APB_MASTER_TIMEOUT_EN defined, a counter SHALL clear on ACCESS entry and count ACCESS cycles with pready=0.
REQ-032 When that count reaches TIMEOUT, the block SHALL abort: return to IDLE, drop psel and penable, and pulse rsp_valid with rsp_err=1 and rsp_rdata=0.
REQ-033 A pready=1 sampled on the same edge as the timeout SHALL win, giving a normal completion.
REQ-034 Without APB_MASTER_TIMEOUT_EN, ACCESS SHALL wait for pready indefinitely, and no counter logic SHALL be present.

Verification
REQ-035 Write: cmd addr=0x05, wdata=0xA5 into apb_slave -> psel/penable follow SETUP then ACCESS; pstrb=1; rsp_valid 4 cycles after accept; rsp_err=0.
REQ-036 Read after write: read addr=0x05 -> rsp_rdata=0xA5, rsp_err=0, pstrb=0 throughout the transfer.
REQ-037 Wait states: completer holds pready low 3 ACCESS cycles -> paddr/pwdata stable throughout; rsp_valid 7 cycles after accept.
REQ-038 Error: completer returns pslverr=1 with pready on a write to 0x10 -> rsp_err=1; next command is accepted normally.
REQ-039 Reset mid-ACCESS: assert rst while penable=1 -> psel and penable drop at once; no rsp_valid; cmd_ready=1 after release.
REQ-040 With APB_MASTER_TIMEOUT_EN and TIMEOUT=16, pready tied low -> rsp_valid with rsp_err=1 and rsp_rdata=0 after 16 ACCESS cycles; then IDLE.
